// File: rtl/ps2_key_mapper.sv
// Keyboard-to-button decoder: maps hps_io ps2_key events onto NUM_BTN held buttons
// through a runtime-writable keymap, with per-button autofire and press strobes.
module ps2_key_mapper #(
    parameter int                      NUM_BTN     = 16,
    parameter logic [NUM_BTN*10-1:0]   DEFAULT_MAP = '0,
    parameter logic [NUM_BTN-1:0]      AF_MASK     = '0,
    parameter int                      AF_W        = 20
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [64:0]         ps2_key,
    input  logic                map_we,
    input  logic [4:0]          map_idx,
    input  logic [9:0]          map_data,
    input  logic                clear,
    input  logic                af_en,
    input  logic [AF_W-1:0]     af_period,
    output logic [NUM_BTN-1:0]  btn_held,
    output logic [NUM_BTN-1:0]  btn_out,
    output logic [NUM_BTN-1:0]  btn_pulse,
    output logic                key_evt
);

    localparam logic [AF_W-1:0] LP_AF_ONE = 1;

    logic [9:0]         r_map [NUM_BTN];
    logic               r_toggle_q;
    logic               r_init;
    logic [NUM_BTN-1:0] r_held;
    logic [NUM_BTN-1:0] r_out;
    logic [NUM_BTN-1:0] r_pulse;
    logic               r_evt;
    logic [AF_W-1:0]    r_af_cnt;
    logic               r_af_phase;

    logic               w_pressed;
    logic               w_extended;
    logic               w_event;
    logic               w_accept;
    logic [NUM_BTN-1:0] w_match;
    logic [NUM_BTN-1:0] w_we_hit;
    logic [NUM_BTN-1:0] w_held_nxt;
    logic [NUM_BTN-1:0] w_af_gate;
    logic               w_af_active;
    logic               w_af_wrap;

    always_comb begin
        w_pressed  = (ps2_key[15:8] != 8'hF0);
        w_extended = w_pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
        w_event    = !r_init && (ps2_key[64] != r_toggle_q);
        // Multi-byte PRNSCR/PAUSE sequences are dropped entirely
        w_accept   = w_event && (ps2_key[63:24] == '0);
    end

    always_comb begin
        w_match  = '0;
        w_we_hit = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            w_match[i]  = (r_map[i][7:0] == ps2_key[7:0]) && (r_map[i][7:0] != '0) &&
                          (r_map[i][9] || (r_map[i][8] == w_extended));
            w_we_hit[i] = map_we && (map_idx == 5'(i));
        end
    end

    // Rewriting an entry releases its button; clear overrides everything
    always_comb begin
        w_held_nxt = r_held;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (w_accept && w_match[i]) begin
                w_held_nxt[i] = w_pressed;
            end
            if (w_we_hit[i]) begin
                w_held_nxt[i] = 1'b0;
            end
        end
        if (clear) begin
            w_held_nxt = '0;
        end
    end

    always_comb begin
        w_af_active = af_en && (|(r_held & AF_MASK));
        w_af_wrap   = (r_af_cnt == (af_period - LP_AF_ONE));
        w_af_gate   = AF_MASK & {NUM_BTN{af_en & ~r_af_phase}};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                r_map[i] <= DEFAULT_MAP[10*i +: 10];
            end
        end else begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                if (w_we_hit[i]) begin
                    r_map[i] <= map_data;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_toggle_q <= 1'b0;
            r_init     <= 1'b1;
            r_held     <= '0;
            r_pulse    <= '0;
            r_evt      <= 1'b0;
        end else begin
            r_toggle_q <= ps2_key[64];
            r_init     <= 1'b0;
            r_held     <= w_held_nxt;
            r_pulse    <= w_held_nxt & ~r_held;
            r_evt      <= w_accept;
        end
    end

    // Counter wraps through 2^AF_W if af_period shrinks below the current count
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_af_cnt   <= '0;
            r_af_phase <= 1'b1;
        end else if (!w_af_active || (af_period == '0)) begin
            r_af_cnt   <= '0;
            r_af_phase <= 1'b1;
        end else if (w_af_wrap) begin
            r_af_cnt   <= '0;
            r_af_phase <= ~r_af_phase;
        end else begin
            r_af_cnt   <= r_af_cnt + LP_AF_ONE;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
        end else begin
            r_out <= r_held & ~w_af_gate;
        end
    end

    assign btn_held  = r_held;
    assign btn_out   = r_out;
    assign btn_pulse = r_pulse;
    assign key_evt   = r_evt;

endmodule

// File: tb/tb_ps2_key_mapper.sv
// Directed bench for ps2_key_mapper: behavioural model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_ps2_key_mapper;

    localparam int             NB   = 16;
    localparam int             AFW  = 6;
    localparam logic [159:0]   TB_MAP  = 160'(10'h029) << 30;
    localparam logic [15:0]    TB_MASK = 16'h0020;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic [64:0]   ps2_key = {1'b1, 40'h0, 8'h00, 8'h00, 8'h29};
    logic          map_we = 1'b0;
    logic [4:0]    map_idx = '0;
    logic [9:0]    map_data = '0;
    logic          clear = 1'b0;
    logic          af_en = 1'b0;
    logic [AFW-1:0] af_period = '0;
    logic [NB-1:0] btn_held, btn_out, btn_pulse;
    logic          key_evt;

    int n_chk = 0;
    int n_err = 0;

    ps2_key_mapper #(
        .NUM_BTN(NB), .DEFAULT_MAP(TB_MAP), .AF_MASK(TB_MASK), .AF_W(AFW)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
        .map_we(map_we), .map_idx(map_idx), .map_data(map_data),
        .clear(clear), .af_en(af_en), .af_period(af_period),
        .btn_held(btn_held), .btn_out(btn_out), .btn_pulse(btn_pulse),
        .key_evt(key_evt)
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- behavioural model ----------------
    logic [9:0]  m_map [NB];
    logic [15:0] m_held, m_out, m_pulse, m_nh;
    logic        m_evt, m_tog, m_init, m_phase;
    int          m_cnt;
    logic        m_press, m_ext, m_acc;
    logic [159:0] m_init_map;
    logic [15:0]  m_mask;

    task automatic model_reset();
        m_init_map = TB_MAP;
        for (int i = 0; i < NB; i++) m_map[i] = m_init_map[10*i +: 10];
        m_held = '0; m_out = '0; m_pulse = '0; m_evt = 1'b0;
        m_tog = 1'b0; m_init = 1'b1; m_phase = 1'b1; m_cnt = 0;
    endtask

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            m_mask  = TB_MASK;
            m_press = (ps2_key[15:8] != 8'hF0);
            m_ext   = m_press ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
            m_acc   = !m_init && (ps2_key[64] != m_tog) && (ps2_key[63:24] == 40'h0);
            for (int i = 0; i < NB; i++)
                m_out[i] = m_held[i] & ((m_mask[i] && af_en) ? m_phase : 1'b1);
            if (!(af_en && ((m_held & m_mask) != 0)) || af_period == 0) begin
                m_cnt = 0; m_phase = 1'b1;
            end else if (m_cnt == int'(af_period) - 1) begin
                m_cnt = 0; m_phase = !m_phase;
            end else begin
                m_cnt = (m_cnt + 1) % (1 << AFW);
            end
            m_nh = m_held;
            if (m_acc)
                for (int i = 0; i < NB; i++)
                    if (m_map[i][7:0] == ps2_key[7:0] && m_map[i][7:0] != 0 &&
                        (m_map[i][9] || m_map[i][8] == m_ext))
                        m_nh[i] = m_press;
            if (map_we && map_idx < NB) begin
                m_nh[map_idx[3:0]] = 1'b0;
                m_map[map_idx[3:0]] = map_data;
            end
            if (clear) m_nh = '0;
            m_pulse = m_nh & ~m_held;
            m_held  = m_nh;
            m_evt   = m_acc;
            m_tog   = ps2_key[64];
            m_init  = 1'b0;
        end
    end

    always @(negedge clk_sys) begin
        n_chk += 4;
        if (btn_held !== m_held) begin
            n_err++; $display("FAIL cyc_held t=%0t got=%h exp=%h", $time, btn_held, m_held);
        end
        if (btn_out !== m_out) begin
            n_err++; $display("FAIL cyc_out t=%0t got=%h exp=%h", $time, btn_out, m_out);
        end
        if (btn_pulse !== m_pulse) begin
            n_err++; $display("FAIL cyc_pulse t=%0t got=%h exp=%h", $time, btn_pulse, m_pulse);
        end
        if (key_evt !== m_evt) begin
            n_err++; $display("FAIL cyc_evt t=%0t got=%b exp=%b", $time, key_evt, m_evt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic send(input logic [39:0] pfx, input logic [7:0] b2, input logic [7:0] b1,
                        input logic [7:0] code);
        ps2_key = {~ps2_key[64], pfx, b2, b1, code};
        step();
    endtask

    task automatic make(input logic ext, input logic [7:0] code);
        send(40'h0, 8'h00, ext ? 8'hE0 : 8'h00, code);
    endtask

    task automatic brk(input logic ext, input logic [7:0] code);
        send(40'h0, ext ? 8'hE0 : 8'h00, 8'hF0, code);
    endtask

    task automatic map_write(input logic [4:0] idx, input logic [9:0] data);
        map_we = 1'b1; map_idx = idx; map_data = data;
        step();
        map_we = 1'b0;
    endtask

    logic [15:0] pat;
    logic        all_one;

    initial begin
        // reset with toggle already high: release must not create an event
        repeat (3) step();
        chk("rst_held", 32'(btn_held), 32'h0);
        chk("rst_out", 32'(btn_out), 32'h0);
        reset_n = 1'b1;
        repeat (3) step();
        chk("init_held", 32'(btn_held), 32'h0);
        chk("init_evt", 32'(key_evt), 32'h0);

        make(1'b0, 8'h29);
        chk("mk29_held", 32'(btn_held), 32'h0008);
        chk("mk29_pulse", 32'(btn_pulse), 32'h0008);
        chk("mk29_evt", 32'(key_evt), 32'h1);
        step();
        chk("mk29_pulse_end", 32'(btn_pulse), 32'h0);
        chk("mk29_evt_end", 32'(key_evt), 32'h0);
        make(1'b0, 8'h29);
        chk("rep_pulse", 32'(btn_pulse), 32'h0);
        chk("rep_evt", 32'(key_evt), 32'h1);

        // extended matching
        map_write(5'd0, 10'h175);
        make(1'b0, 8'h75);
        chk("ext_plain", 32'(btn_held), 32'h0008);
        make(1'b1, 8'h75);
        chk("ext_make", 32'(btn_held), 32'h0009);
        chk("ext_pulse", 32'(btn_pulse), 32'h0001);
        brk(1'b1, 8'h75);
        chk("ext_break", 32'(btn_held), 32'h0008);
        map_write(5'd0, 10'h375);
        make(1'b0, 8'h75);
        chk("dc_plain_mk", 32'(btn_held), 32'h0009);
        brk(1'b0, 8'h75);
        chk("dc_plain_brk", 32'(btn_held), 32'h0008);
        make(1'b1, 8'h75);
        chk("dc_ext_mk", 32'(btn_held), 32'h0009);
        brk(1'b1, 8'h75);
        chk("dc_ext_brk", 32'(btn_held), 32'h0008);

        // PRNSCR sequence is dropped even though entry 4 codes 0x7C
        map_write(5'd4, 10'h07C);
        send(40'h00_0000_E012, 8'h00, 8'hE0, 8'h7C);
        chk("prn_evt", 32'(key_evt), 32'h0);
        chk("prn_held", 32'(btn_held), 32'h0008);
        make(1'b0, 8'h7C);
        chk("mk7c_held", 32'(btn_held), 32'h0018);

        // autofire on button 5, period 4
        map_write(5'd5, 10'h01C);
        map_write(5'd6, 10'h01B);
        af_en = 1'b1; af_period = 6'd4;
        make(1'b0, 8'h1C);
        chk("af_held", 32'(btn_held[5]), 32'h1);
        chk("af_out_lag", 32'(btn_out[5]), 32'h0);
        pat = '0;
        for (int i = 0; i < 16; i++) begin
            step();
            pat = {pat[14:0], btn_out[5]};
        end
        chk("af_pattern", 32'(pat), 32'h0000F0F0);
        make(1'b0, 8'h1B);
        step();
        chk("af_unmasked", 32'(btn_out[6]), 32'h1);

        af_period = 6'd0;
        repeat (2) step();
        all_one = 1'b1;
        for (int i = 0; i < 5; i++) begin
            all_one &= btn_out[5];
            step();
        end
        chk("af_p0_const", 32'(all_one), 32'h1);

        // shrinking the period below the running count wraps through 2^AF_W
        af_period = 6'd8;
        repeat (6) step();
        af_period = 6'd3;
        all_one = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            all_one &= btn_out[5];
        end
        chk("af_wrap_hold", 32'(all_one), 32'h1);
        repeat (30) step();

        // reset in the middle of an autofire run
        af_period = 6'd2;
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        chk("async_held", 32'(btn_held), 32'h0);
        chk("async_out", 32'(btn_out), 32'h0);
        chk("async_evt", 32'(key_evt), 32'h0);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (2) step();
        chk("rel_held", 32'(btn_held), 32'h0);
        map_write(5'd5, 10'h01C);
        af_period = 6'd4;
        make(1'b0, 8'h1C);
        chk("rel_af_held", 32'(btn_held), 32'h0020);
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            pat = {pat[14:0], btn_out[5]};
        end
        chk("rel_af_pattern", 32'(pat), 32'h000000F0);

        // same-cycle event and write to the matching entry
        af_en = 1'b0;
        map_write(5'd2, 10'h02A);
        ps2_key = {~ps2_key[64], 40'h0, 8'h00, 8'h00, 8'h2A};
        map_we = 1'b1; map_idx = 5'd2; map_data = 10'h02B;
        step();
        map_we = 1'b0;
        chk("we_evt_held", 32'(btn_held), 32'h0020);
        chk("we_evt_evt", 32'(key_evt), 32'h1);
        make(1'b0, 8'h2B);
        chk("we_new_code", 32'(btn_held), 32'h0024);
        brk(1'b0, 8'h2A);
        chk("we_old_code", 32'(btn_held), 32'h0024);

        // clear beats a same-cycle make
        ps2_key = {~ps2_key[64], 40'h0, 8'h00, 8'h00, 8'h29};
        clear = 1'b1;
        step();
        chk("clr_held", 32'(btn_held), 32'h0);
        map_we = 1'b1; map_idx = 5'd7; map_data = 10'h033;
        step();
        map_we = 1'b0; clear = 1'b0;
        make(1'b0, 8'h33);
        chk("clr_map_written", 32'(btn_held), 32'h0080);

        // out-of-range index leaves the table alone
        map_write(5'd31, 10'h02B);
        make(1'b0, 8'h2B);
        chk("idx31_ignored", 32'(btn_held), 32'h0084);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_key_mapper.md
Name: ps2_key_mapper

Overview:
- Generalised keyboard-to-button decoder for arcade cores.
- Consumes the hps_io ps2_key bus and maintains NUM_BTN held-button registers through a runtime-writable keymap.
- Adds per-button autofire, press pulses and a synchronous clear.
- Sits between hps_io and the core's control mux; replaces hand-written per-core casex key decoders.

Parameters:
- NUM_BTN, 16, number of mapped buttons (1..32).
- DEFAULT_MAP, all-zero vector of NUM_BTN*10 bits, reset keymap. Entry i occupies bits [10i+9:10i] = {ext_dc, ext, code[7:0]}.
- AF_MASK, 0 (NUM_BTN bits), buttons eligible for autofire.
- AF_W, 20, width of the autofire period counter.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- ps2_key  in  65  hps_io key bus: [64] toggle, [63:24] prefix bytes, [15:8] F0/E0, [7:0] scancode
- map_we  in  1  keymap write strobe
- map_idx  in  5  entry index to write
- map_data  in  10  {ext_dc, ext, code}
- clear  in  1  synchronous release of all buttons
- af_en  in  1  global autofire enable
- af_period  in  AF_W  half-period of autofire, in clk_sys cycles
- btn_held  out  NUM_BTN  raw key state
- btn_out  out  NUM_BTN  held state with autofire gating applied
- btn_pulse  out  NUM_BTN  one-cycle strobe on a 0->1 transition of btn_held
- key_evt  out  1  one-cycle strobe per accepted ps2_key event

Behaviour:
- Reset (async, reset_n=0):
  - btn_held, btn_pulse and key_evt = 0; btn_out = 0.
  - Keymap loads DEFAULT_MAP.
  - Autofire counter = 0; af_phase = 1.
  - toggle_q = 0; init flag set.
- First cycle after reset release: toggle_q <= ps2_key[64], no event generated; init flag cleared.
- Event detect: ps2_key[64] != toggle_q, init clear. toggle_q follows ps2_key[64] every cycle.
- Decode (combinational on ps2_key):
  - pressed = ps2_key[15:8] != 8'hF0.
  - extended = pressed ? (ps2_key[15:8]==8'hE0) : (ps2_key[23:16]==8'hE0).
  - If ps2_key[63:24] != 0 (PRNSCR/PAUSE), the event is dropped: key_evt stays 0.
- Match, for every entry i in parallel:
  - Entry matches when code[7:0] == ps2_key[7:0], code != 0, and (ext_dc | ext == extended).
  - An entry with code 0 is disabled.
  - Multiple matching entries all update.
- Latency: btn_held[i] <= pressed at the edge ending the event cycle; visible 1 cycle after the toggle change. key_evt is asserted in that same output cycle.
- btn_pulse[i] = 1 for exactly one cycle when btn_held[i] goes 0->1. A repeated make of a held key gives no pulse.
- map_we:
  - Writes entry map_idx at the clock edge.
  - map_idx >= NUM_BTN: write ignored.
  - The written entry's btn_held bit is forced to 0 (no stuck buttons).
  - Same-cycle event matches against the old table; the forced clear wins for that index.
- clear: btn_held <= 0 for all bits. Priority over any same-cycle event and over a map_we write's data path; the keymap itself is still written.
- Autofire:
  - active = af_en & |(btn_held & AF_MASK).
  - When active=0: counter <= 0, af_phase <= 1.
  - When active=1 and af_period != 0: the counter increments. When counter == af_period-1 it wraps to 0 and af_phase toggles.
  - af_period = 0: af_phase held at 1.
  - A change of af_period mid-run takes effect at the next compare. If the counter is already >= the new af_period-1, it wraps through 2^AF_W.
- btn_out[i] = btn_held[i] & (AF_MASK[i] & af_en ? af_phase : 1), registered (1 cycle after btn_held).
- First autofire press therefore fires immediately for af_period cycles.
- Reset mid-operation: all state returns to reset values at once. A toggle change in flight is not replayed (init-flag rule).

Test Plan:
- Reset with ps2_key[64]=1, release -> no key_evt, btn_held=0. Then send make 0x029 with entry 3 = {0,0,0x29} -> btn_held[3]=1 one cycle after toggle, btn_pulse[3] for one cycle, key_evt=1.
- Entry 0={0,1,0x75}: send make 0x75 without E0 -> no change. Send E0 make 0x75 -> btn_held[0]=1. Send E0,F0 break 0x75 -> btn_held[0]=0. Set ext_dc=1: both variants set it.
- Send E0 12 E0 7C (PRNSCR, ps2_key[63:24]!=0) -> key_evt=0, no bit changes, even with an entry coded 0x7C.
- Hold btn 5 (AF_MASK[5]=1), af_en=1, af_period=4 -> btn_out[5] pattern 1111 0000 1111... starting 1 cycle after btn_held. af_period=0 -> constant 1. btn 6 (not masked) always follows btn_held.
- Same cycle: make on entry 2's key plus map_we to idx 2 -> btn_held[2]=0 and entry 2 updated. clear together with any make -> all btn_held=0. map_idx=31 with NUM_BTN=16 -> table unchanged.
- Assert reset_n low mid autofire run -> outputs 0 asynchronously. After release, af_phase=1 and counter=0 on the next press.
